// File: rtl/phase_shift_check_multi_pkg.sv
// Shared FSM encoding and elaboration-time helpers for the multi-channel phase-shift checker.
// Optional statistics outputs are enabled by defining PHASE_SHIFT_CHECK_STATS_EN.
package phase_shift_check_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    // Expected delay in samples for a shift in degrees, rounded to nearest.
    function automatic int exp_count(input int deg, input int period);
        return (deg * period + 180) / 360;
    endfunction

    // Error measured around the period circle, so a capture just before the
    // reference edge is close to an expected value of zero.
    function automatic int circ_err(input int meas, input int expd, input int period);
        int d;
        d = (meas > expd) ? meas - expd : expd - meas;
        return (d < period - d) ? d : period - d;
    endfunction

endpackage

// File: rtl/phase_shift_channel.sv
// One checked channel: synchronizer, edge detect, delay counter, compare and sticky fail.
// Adds a saturating error counter when PHASE_SHIFT_CHECK_STATS_EN is defined.
module phase_shift_channel
    import phase_shift_check_multi_pkg::*;
#(
    parameter int PERIOD_SAMPLES = 40,
    parameter int EXPECTED       = 0,
    parameter int TOLERANCE      = 1,
    parameter int CNT_W          = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_shifted,
    input  logic             ref_rise,
    input  logic             measure_en,
    output logic             fail_ch,
    output logic [CNT_W-1:0] measured,
    output logic             measured_valid
`ifdef PHASE_SHIFT_CHECK_STATS_EN
    ,
    output logic [15:0]      err_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERIOD_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_SAMPLES - 1);

    logic [2:0]       sync;
    logic             ch_rise;
    logic [CNT_W-1:0] count;
    logic             armed;
    logic             miss;
    logic             bad;

    assign ch_rise = sync[1] & ~sync[2];

    // A missing edge is flagged once: either at saturation or at the next reference edge.
    assign miss = measure_en & armed &
                  ((ref_rise & (count != CNT_MAX)) |
                   (~ref_rise & ~ch_rise & (count == CNT_LAST)));

    assign bad = measured_valid &&
                 (circ_err(int'(measured), EXPECTED, PERIOD_SAMPLES) > TOLERANCE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync           <= '0;
            count          <= '0;
            armed          <= 1'b0;
            measured       <= '0;
            measured_valid <= 1'b0;
            fail_ch        <= 1'b0;
        end else begin
            sync           <= {sync[1:0], clk_shifted};
            measured_valid <= 1'b0;
            if (miss | bad)
                fail_ch <= 1'b1;
            if (!measure_en) begin
                armed <= 1'b0;
                count <= '0;
            end else if (ref_rise) begin
                count <= '0;
                armed <= ~ch_rise;
                if (ch_rise) begin
                    measured       <= '0;
                    measured_valid <= 1'b1;
                end
            end else if (armed) begin
                // count lags elapsed cycles by one, so the capture adds it back
                if (ch_rise) begin
                    measured       <= (count == CNT_MAX) ? CNT_MAX : count + 1'b1;
                    measured_valid <= 1'b1;
                    armed          <= 1'b0;
                end else if (count != CNT_MAX) begin
                    count <= count + 1'b1;
                end
            end
        end
    end

`ifdef PHASE_SHIFT_CHECK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if ((miss | bad) && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: rtl/phase_shift_check_multi.sv
// Multi-channel PLL phase-shift checker: reference synchronizer, lock/settle FSM, fail OR.
// Define PHASE_SHIFT_CHECK_STATS_EN to add err_count and check_count outputs.
module phase_shift_check_multi
    import phase_shift_check_multi_pkg::*;
#(
    parameter int                    CHANNELS       = 2,
    parameter int                    PERIOD_SAMPLES = 40,
    parameter logic [CHANNELS*9-1:0] SHIFT_DEG      = {9'd90, 9'd0},
    parameter int                    TOLERANCE      = 1,
    parameter int                    SETTLE_PERIODS = 2,
    localparam int                   CNT_W          = $clog2(PERIOD_SAMPLES + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clk_ref,
    input  logic [CHANNELS-1:0]            clk_shifted,
    input  logic                           LOCKED,
    output logic [CHANNELS-1:0]            fail_ch,
    output logic                           fail,
    output logic [CHANNELS-1:0][CNT_W-1:0] measured,
    output logic [CHANNELS-1:0]            measured_valid
`ifdef PHASE_SHIFT_CHECK_STATS_EN
    ,
    output logic [CHANNELS-1:0][15:0]      err_count,
    output logic [31:0]                    check_count
`endif
);

    state_t      state, state_nxt;
    logic [2:0]  ref_sync;
    logic        ref_rise;
    logic [15:0] settle_cnt;
    logic        measure_en;

    assign ref_rise = ref_sync[1] & ~ref_sync[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ref_sync   <= '0;
            settle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ref_sync <= {ref_sync[1:0], clk_ref};
            if (state != ST_SETTLE)
                settle_cnt <= '0;
            else if (ref_rise)
                settle_cnt <= settle_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!LOCKED) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_SETTLE;
                ST_SETTLE:  if (ref_rise && settle_cnt == 16'(SETTLE_PERIODS - 1))
                                state_nxt = ST_MEASURE;
                ST_MEASURE: state_nxt = ST_MEASURE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        measure_en = (state == ST_MEASURE);
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        phase_shift_channel #(
            .PERIOD_SAMPLES (PERIOD_SAMPLES),
            .EXPECTED       (exp_count(int'(SHIFT_DEG[9*g +: 9]), PERIOD_SAMPLES)),
            .TOLERANCE      (TOLERANCE),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .clk_shifted    (clk_shifted[g]),
            .ref_rise       (ref_rise),
            .measure_en     (measure_en),
            .fail_ch        (fail_ch[g]),
            .measured       (measured[g]),
            .measured_valid (measured_valid[g])
`ifdef PHASE_SHIFT_CHECK_STATS_EN
            ,
            .err_count      (err_count[g])
`endif
        );
    end

    assign fail = |fail_ch;

`ifdef PHASE_SHIFT_CHECK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            check_count <= '0;
        else if (measure_en && ref_rise && check_count != 32'hFFFF_FFFF)
            check_count <= check_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_phase_shift_check_multi.sv
// Directed bench: 40-sample reference, channels at 0 and 90 degrees, tolerance 1.
// Stats outputs are checked only when PHASE_SHIFT_CHECK_STATS_EN is defined.
module tb_phase_shift_check_multi;

    localparam int CH = 2;
    localparam int P  = 40;
    localparam int CW = 6;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clk_ref;
    logic [CH-1:0]          clk_shifted;
    logic                   LOCKED;
    logic [CH-1:0]          fail_ch;
    logic                   fail;
    logic [CH-1:0][CW-1:0]  measured;
    logic [CH-1:0]          measured_valid;
`ifdef PHASE_SHIFT_CHECK_STATS_EN
    logic [CH-1:0][15:0]    err_count;
    logic [31:0]            check_count;
`endif

    int tests = 0;
    int fails = 0;
    int phase = 0;
    int dly[CH]      = '{0, 20};
    logic [CH-1:0] ch_off = '0;
    int exp_cap[CH]  = '{0, 10};
    int cap_cnt[CH]  = '{0, 0};
    int last_cap[CH] = '{0, 0};
    int odd_cnt[CH]  = '{0, 0};

    phase_shift_check_multi dut (
        .clk            (clk),
        .rst            (rst),
        .clk_ref        (clk_ref),
        .clk_shifted    (clk_shifted),
        .LOCKED         (LOCKED),
        .fail_ch        (fail_ch),
        .fail           (fail),
        .measured       (measured),
        .measured_valid (measured_valid)
`ifdef PHASE_SHIFT_CHECK_STATS_EN
        ,
        .err_count      (err_count),
        .check_count    (check_count)
`endif
    );

    always #5 clk = ~clk;

    // Clock waveforms derived from a shared phase counter; delays in sample cycles.
    initial begin
        clk_ref     = 1'b0;
        clk_shifted = '0;
        forever begin
            @(negedge clk);
            phase   = (phase + 1) % P;
            clk_ref = (phase < P / 2);
            for (int i = 0; i < CH; i++)
                clk_shifted[i] = !ch_off[i] && (((phase - dly[i] + P) % P) < P / 2);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (measured_valid[i] === 1'b1) begin
                cap_cnt[i]  = cap_cnt[i] + 1;
                last_cap[i] = int'(measured[i]);
                if (int'(measured[i]) != exp_cap[i])
                    odd_cnt[i] = odd_cnt[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int c0, c1, o0, o1;
        int k;

        rst    = 1'b1;
        LOCKED = 1'($urandom_range(0, 1));
        wait_cyc(3);
        check("reset_fail", 32'(fail), 32'd0);
        check("reset_fail_ch", 32'(fail_ch), 32'd0);
        check("reset_measured", 32'(measured), 32'd0);
        check("reset_valid", 32'(measured_valid), 32'd0);
`ifdef PHASE_SHIFT_CHECK_STATS_EN
        check("reset_err_count", 32'(err_count), 32'd0);
        check("reset_check_count", check_count, 32'd0);
`endif

        // Unlocked with channel 1 at 180 degrees: nothing is checked.
        rst    = 1'b0;
        LOCKED = 1'b0;
        c0 = cap_cnt[0]; c1 = cap_cnt[1];
        wait_cyc(400);
        check("unlocked_fail", 32'(fail), 32'd0);
        check("unlocked_no_capture", 32'(cap_cnt[0] + cap_cnt[1] - c0 - c1), 32'd0);

        // Locked with correct shifts.
        dly[1] = 10;
        wait_cyc(40);
        c0 = cap_cnt[0]; c1 = cap_cnt[1]; o0 = odd_cnt[0]; o1 = odd_cnt[1];
        LOCKED = 1'b1;
        wait_cyc(2000);
        check("locked_fail", 32'(fail), 32'd0);
        check("locked_fail_ch", 32'(fail_ch), 32'd0);
        check("locked_caps_ch0", 32'(cap_cnt[0] - c0 >= 45), 32'd1);
        check("locked_caps_ch1", 32'(cap_cnt[1] - c1 >= 45), 32'd1);
        check("locked_values_ch0", 32'(odd_cnt[0] - o0), 32'd0);
        check("locked_values_ch1", 32'(odd_cnt[1] - o1), 32'd0);
        check("locked_last_ch0", 32'(last_cap[0]), 32'd0);
        check("locked_last_ch1", 32'(last_cap[1]), 32'd10);

        // Channel 1 at 135 degrees: 15 samples vs expected 10.
        dly[1] = 15;
        for (k = 0; k < 120 && fail_ch != 2'b10; k++)
            wait_cyc(1);
        check("shift135_fail_ch", 32'(fail_ch), 32'd2);
        check("shift135_fail", 32'(fail), 32'd1);
        check("shift135_last_ch1", 32'(last_cap[1]), 32'd15);
        dly[1] = 10;
        wait_cyc(200);
        check("sticky_after_restore", 32'(fail_ch), 32'd2);
        LOCKED = 1'b0;
        wait_cyc(50);
        check("sticky_after_unlock", 32'(fail), 32'd1);
        LOCKED = 1'b1;

        // Channel 0 at 39 samples: circular error 1, within tolerance.
        rst = 1'b1;
        dly[0] = 39;
        exp_cap[0] = 39;
        wait_cyc(3);
        check("rst_clears_fail", 32'(fail), 32'd0);
        rst = 1'b0;
        c0 = cap_cnt[0]; o0 = odd_cnt[0];
        wait_cyc(400);
        check("wrap39_fail_ch", 32'(fail_ch), 32'd0);
        check("wrap39_last_ch0", 32'(last_cap[0]), 32'd39);
        check("wrap39_values_ch0", 32'(odd_cnt[0] - o0), 32'd0);
        check("wrap39_caps_ch0", 32'(cap_cnt[0] - c0 >= 5), 32'd1);
        check("wrap39_last_ch1", 32'(last_cap[1]), 32'd10);

        // Channel 0 at 37 samples: circular error 3, out of tolerance.
        rst = 1'b1;
        dly[0] = 37;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(400);
        check("wrap37_fail_ch", 32'(fail_ch), 32'd1);
        check("wrap37_last_ch0", 32'(last_cap[0]), 32'd37);

        // Channel 0 held low: missing edges.
        rst = 1'b1;
        dly[0] = 0;
        ch_off[0] = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        c0 = cap_cnt[0];
        wait_cyc(400);
        check("missing_fail_ch", 32'(fail_ch), 32'd1);
        check("missing_fail", 32'(fail), 32'd1);
        check("missing_no_capture", 32'(cap_cnt[0] - c0), 32'd0);
`ifdef PHASE_SHIFT_CHECK_STATS_EN
        check("missing_check_count_run", 32'(check_count >= 32'd5), 32'd1);
        check("missing_err_count_ch0", 32'(err_count[0]), check_count - 32'd1);
        check("missing_err_count_ch1", 32'(err_count[1]), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
